// File: rtl/count7seg_pkg.sv
// Seven-segment patterns (active-low, {dp,g,f,e,d,c,b,a}) and the BCD decode
// shared by the counter/display blocks.
package count7seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Button synchroniser + debouncer; emits a one-cycle pulse 2+CYCLES cycles after
// a clean rising edge. A button already held when reset releases never pulses.
module debounce_pulse #(
    parameter int CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    localparam int TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          armed_q;
    logic          pulse_q;
    logic [TW-1:0] timer_q;
    logic          accept;

    assign accept = (sync_q[1] != stable_q) && (timer_q == TW'(CYCLES - 1));

    // Synchroniser resets to "pressed" so a button held through reset is only
    // armed once it has actually been seen released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            pulse_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], in};
            pulse_q <= accept && sync_q[1] && armed_q;
            if (!sync_q[1]) begin
                armed_q <= 1'b1;
            end
            if (sync_q[1] == stable_q) begin
                timer_q <= '0;
            end else if (accept) begin
                stable_q <= sync_q[1];
                timer_q  <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter driven by debounced buttons, with a scanned
// common-anode 7-segment output; seg/anode/wrap are registered.
module bcd_counter_display
    import count7seg_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 100000,
    parameter int BLANK_LZ        = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              countup,
    input  logic              countdown,
    input  logic              clear,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] anode,
    output logic              wrap
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic up_p, dn_p, clr_p;

    debounce_pulse #(.CYCLES(DEBOUNCE_CYCLES)) u_up  (.clock(clock), .reset(reset), .in(countup),   .pulse(up_p));
    debounce_pulse #(.CYCLES(DEBOUNCE_CYCLES)) u_dn  (.clock(clock), .reset(reset), .in(countdown), .pulse(dn_p));
    debounce_pulse #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (.clock(clock), .reset(reset), .in(clear),     .pulse(clr_p));

    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic                   wrap_q, wrap_d;
    logic [SW-1:0]          scan_q, scan_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [DIGITS-1:0]      blank;
    logic                   carry;
    logic                   zrun;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        if (clr_p) begin
            count_d = '0;
        end else if (up_p && !dn_p) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[i] == 4'd9) begin
                        count_d[i] = 4'd0;
                    end else begin
                        count_d[i] = count_q[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end else if (dn_p && !up_p) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[i] == 4'd0) begin
                        count_d[i] = 4'd9;
                    end else begin
                        count_d[i] = count_q[i] - 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        blank = '0;
        zrun  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun     = zrun && (count_q[i] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && zrun;
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_CYCLES - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        anode_d = ~(DIGITS'(1) << idx_q);
        seg_d   = blank[idx_q] ? SEG_BLANK : bcd_to_seg(count_q[idx_q]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            anode_q <= '1;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    assign seg   = seg_q;
    assign anode = anode_q;
    assign wrap  = wrap_q;

endmodule
